// File: rtl/mem_hs_ram_if.sv
// Request/acknowledge bus between the control unit (master) and mem_hs_ram (slave).
// Carries the latched-on-accept request fields and the registered load/fault results.
interface mem_hs_ram_if #(
   parameter int ADDR_W = 9
);
   logic              mov;
   logic              rw;
   logic [1:0]        size;
   logic              sext;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       data_in;
   logic [31:0]       data_out;
   logic              moc;
   logic              err;

   modport master (
      output mov, rw, size, sext, addr, data_in,
      input  data_out, moc, err
   );

   modport slave (
      input  mov, rw, size, sext, addr, data_in,
      output data_out, moc, err
   );
endinterface

// File: rtl/mem_hs_ram.sv
// Byte-addressable big-endian RAM with MOV/MOC handshake, programmable latency,
// byte/halfword/word sizing with sign/zero extension, and alignment-fault reporting.
module mem_hs_ram #(
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   mem_hs_ram_if.slave bus
);
   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [3:0]        cnt;
   logic              accept;
   logic              access;
   logic              leave_ack;

   logic              req_rw;
   logic              req_sext;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic [31:0]       data_out_q;
   logic              err_q;

   logic [7:0]        mem [0:DEPTH-1];

   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic [7:0]        b0, b1, b2, b3;
   logic              misaligned;
   logic [31:0]       load_val;
   logic              wr_en;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      access    = 1'b0;
      leave_ack = 1'b0;
      case (state)
         S_IDLE: if (bus.mov) begin
            accept   = 1'b1;
            state_nx = S_BUSY;
         end
         S_BUSY: if (cnt == 4'd0) begin
            access   = 1'b1;
            state_nx = S_ACK;
         end
         S_ACK: if (!bus.mov) begin
            leave_ack = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Request fields are captured once on acceptance and never looked at again.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_rw    <= bus.rw;
         req_sext  <= bus.sext;
         req_size  <= bus.size;
         req_addr  <= bus.addr;
         req_wdata <= bus.data_in;
      end
   end

   always_comb begin
      a0 = req_addr;
      a1 = req_addr + ADDR_W'(1);
      a2 = req_addr + ADDR_W'(2);
      a3 = req_addr + ADDR_W'(3);
      b0 = mem[a0];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];
      case (req_size)
         2'b00: begin
            misaligned = 1'b0;
            load_val   = {{24{req_sext & b0[7]}}, b0};
         end
         2'b01: begin
            misaligned = req_addr[0];
            load_val   = {{16{req_sext & b0[7]}}, b0, b1};
         end
         default: begin
            misaligned = |req_addr[1:0];
            load_val   = {b0, b1, b2, b3};
         end
      endcase
      wr_en = access & ~req_rw & ~misaligned & ~reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= 4'd0;
         data_out_q <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         if (accept)                            cnt <= CNT_INIT;
         else if (state == S_BUSY && cnt != 0)  cnt <= cnt - 4'd1;

         if (access) begin
            err_q <= misaligned;
            if (misaligned)  data_out_q <= 32'd0;
            else if (req_rw) data_out_q <= load_val;
         end else if (leave_ack) begin
            err_q <= 1'b0;
         end
      end
   end

   // NOTE: the storage array has no reset; its contents survive reset by design.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         case (req_size)
            2'b00: mem[a0] <= req_wdata[7:0];
            2'b01: begin
               mem[a0] <= req_wdata[15:8];
               mem[a1] <= req_wdata[7:0];
            end
            default: begin
               mem[a0] <= req_wdata[31:24];
               mem[a1] <= req_wdata[23:16];
               mem[a2] <= req_wdata[15:8];
               mem[a3] <= req_wdata[7:0];
            end
         endcase
      end
   end

   assign bus.moc      = (state == S_ACK);
   assign bus.data_out = data_out_q;
   assign bus.err      = err_q;
endmodule
